// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// Optional subtract support is enabled with NIBBLE_SERIAL_ADDER_SUB_EN.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slice passes needed for an operand of the given width.
  function automatic int num_nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice, shared by every
// nibble pass of the serial controller.
module nibble_cla_slice
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s4,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = a4 & b4;
  assign p = a4 ^ b4;

  // Every carry is expanded directly from cin so none waits on a lower bit.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s4   = p ^ c[NIBBLE_W-1:0];
  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a shared CLA slice.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to add the sub port and subtract support.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16  // multiple of NIBBLE_W, at least NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int NIBBLES = num_nibbles(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int MSB     = WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;     // holds the effective (possibly inverted) b
  logic                carry_q;
  logic [IDX_W-1:0]    idx;

  logic [WIDTH-1:0]    b_eff;
  logic                cin_init;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;

  // NOTE: defaults first so every path assigns every output -- no latch.
  always_comb begin
    b_eff    = b;
    cin_init = ci;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_eff    = ~b;
      cin_init = ~ci;
    end
`endif
  end

  assign slice_a = a_q[idx*NIBBLE_W +: NIBBLE_W];
  assign slice_b = b_q[idx*NIBBLE_W +: NIBBLE_W];

  nibble_cla_slice u_slice (
    .a4   (slice_a),
    .b4   (slice_b),
    .cin  (carry_q),
    .s4   (slice_s),
    .cout (slice_cout)
  );

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      idx       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b_eff;
            carry_q  <= cin_init;
            sum      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end

        RUN: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= slice_s;
          carry_q <= slice_cout;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            co        <= slice_cout;
            // slice_s[3] is the final sum MSB on the last pass.
            ovf       <= (a_q[MSB] == b_q[MSB]) && (slice_s[NIBBLE_W-1] != a_q[MSB]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16); covers the
// subtract cases only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;

  localparam int W       = 16;
  localparam int NIBBLES = W / 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                 input logic op_ci, input logic op_sub);
    exp_t         e;
    logic [W-1:0] beff;
    logic         cin;
    logic [W:0]   full;
    beff  = op_sub ? ~op_b : op_b;
    cin   = op_sub ? ~op_ci : op_ci;
    full  = {1'b0, op_a} + {1'b0, beff} + {{W{1'b0}}, cin};
    e.sum = full[W-1:0];
    e.co  = full[W];
    e.ovf = (op_a[W-1] == beff[W-1]) && (full[W-1] != op_a[W-1]);
    return e;
  endfunction

  // Issue one operation, check latency, hold the result for `hold` extra
  // cycles (optionally offering a competing input), then release it.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_ci, input logic op_sub,
                        input int hold, input bit compete);
    exp_t e;
    int   edges;
    @(negedge clk);
    edges = 0;
    while (in_ready !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check("idle_wait", {31'd0, in_ready}, 32'd1);
    if (in_ready !== 1'b1) return;

    a = op_a; b = op_b; ci = op_ci; sub = op_sub; in_valid = 1'b1;
    exp_q.push_back(model(op_a, op_b, op_ci, op_sub));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    @(negedge clk);
    check("sum_clear", {16'd0, sum}, 32'd0);
    check("busy_ready", {31'd0, in_ready}, 32'd0);

    edges = 0;
    while (out_valid !== 1'b1 && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("latency", edges, NIBBLES);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();

    for (int h = 0; h <= hold; h++) begin
      if (compete && h == 0) begin
        a = 16'h1111; b = 16'h1111; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end
      check("sum",       {16'd0, sum},       {16'd0, e.sum});
      check("co",        {31'd0, co},        {31'd0, e.co});
      check("ovf",       {31'd0, ovf},       {31'd0, e.ovf});
      check("out_valid", {31'd0, out_valid}, 32'd1);
      check("in_ready",  {31'd0, in_ready},  32'd0);
      if (h < hold) @(negedge clk);
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_ready", {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum",       {16'd0, sum},       32'd0);
    check("rst_co",        {31'd0, co},        32'd0);
    check("rst_ovf",       {31'd0, ovf},       32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 0, 1'b0);
    run_op(16'h2468, 16'h1357, 1'b1, 1'b0, 5, 1'b1);

    // Abort mid-RUN: accept, two RUN edges, then reset.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready",  {31'd0, in_ready},  32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_sum",       {16'd0, sum},       32'd0);
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
`endif

    for (int i = 0; i < 16; i++) begin
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), 1'b0);
`else
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0,
             int'($urandom_range(0, 2)), 1'b0);
`endif
    end

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
